hls2x8_div_seq: RTL and testbench

Sequential signed integer divider: the inverse arithmetic companion of the HLS2x8 datapath's single-cycle signed multiplier. It accepts a dividend/divisor pair through the ap_ctrl_hs-style handshake and runs a radix-2 restoring division, one quotient bit per cycle. It returns a truncated-toward-zero quotient and remainder, plus divide-by-zero and overflow flags. It sits beside the multiplier in the HLS2x8 compute stage and is shared by any datapath needing division without a combinational array divider.

---
 rtl/hls2x8_pkg.sv | 23 ++
 rtl/hls2x8_udiv_step.sv | 25 ++
 rtl/hls2x8_div_seq.sv | 143 ++++++++++++++
 tb/tb_hls2x8_div_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hls2x8_pkg.sv
// rtl/hls2x8_pkg.sv - shared types and constants for the HLS2x8 compute stage
package hls2x8_pkg;

  localparam int DIV_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Most-negative two's complement value of width w, right-aligned in 64 bits
  function automatic logic [63:0] most_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  // Most-positive two's complement value of width w, right-aligned in 64 bits
  function automatic logic [63:0] most_pos(input int unsigned w);
    return most_neg(w) - 64'd1;
  endfunction

endpackage

// File: rtl/hls2x8_udiv_step.sv
// rtl/hls2x8_udiv_step.sv - one combinational restoring-division step on magnitudes
module hls2x8_udiv_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem_in,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor_mag,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // Shift in the next dividend bit, trial-subtract, keep the difference when it does not borrow.
  // With a non-zero divisor rem_in < divisor_mag <= 2^(W-1), so shifted never reaches bit W
  // and diff[W] is a true borrow.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {1'b0, divisor_mag};
    q_bit   = ~diff[W];
    rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
  end

endmodule

// File: rtl/hls2x8_div_seq.sv
// rtl/hls2x8_div_seq.sv - sequential radix-2 signed divider with ap_ctrl_hs handshake
import hls2x8_pkg::*;

module hls2x8_div_seq #(
  parameter int DATA_WIDTH = DIV_W_DEFAULT
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = DATA_WIDTH'(most_neg(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] MOST_POS = DATA_WIDTH'(most_pos(DATA_WIDTH));

  div_state_t            state_q;
  div_state_t            state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] rem_q;       // partial remainder magnitude
  logic [DATA_WIDTH-1:0] dvd_q;       // dividend magnitude, becomes quotient magnitude
  logic [DATA_WIDTH-1:0] dsr_q;       // divisor magnitude
  logic [DATA_WIDTH-1:0] num_q;       // raw dividend, returned as remainder on divide-by-zero
  logic                  neg_num_q;   // dividend negative: remainder takes its sign
  logic                  neg_quo_q;   // operand signs differ: quotient is negative
  logic                  dbz_q;
  logic                  ovf_q;

  logic [DATA_WIDTH-1:0] dividend_mag;
  logic [DATA_WIDTH-1:0] divisor_mag;
  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_q;
  logic                  last_step;

  // Magnitudes as W-bit unsigned; the most-negative value maps to 2^(W-1) without loss
  always_comb begin
    dividend_mag = dividend[DATA_WIDTH-1] ? -dividend : dividend;
    divisor_mag  = divisor[DATA_WIDTH-1]  ? -divisor  : divisor;
    last_step    = (cnt_q == CNT_W'(DATA_WIDTH - 1));
  end

  hls2x8_udiv_step #(
    .W (DATA_WIDTH)
  ) u_step (
    .rem_in       (rem_q),
    .dividend_bit (dvd_q[DATA_WIDTH-1]),
    .divisor_mag  (dsr_q),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed-length walk IDLE -> CALC x W -> FIX -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ap_start) state_d = CALC;
      CALC:    if (last_step) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; ap_ready is combinational so operands are consumed in the accept cycle
  always_comb begin
    ap_idle  = (state_q == IDLE);
    ap_ready = (state_q == IDLE) && ap_start;
    ap_done  = (state_q == DONE);
  end

  // Datapath: operand capture, one restoring step per CALC cycle, sign fix-up into result registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      num_q       <= '0;
      neg_num_q   <= 1'b0;
      neg_quo_q   <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ap_start) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= dividend_mag;
            dsr_q     <= divisor_mag;
            num_q     <= dividend;
            neg_num_q <= dividend[DATA_WIDTH-1];
            neg_quo_q <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
            dbz_q     <= (divisor == '0);
            ovf_q     <= (dividend == MOST_NEG) && (divisor == '1);
          end
        end
        CALC: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[DATA_WIDTH-2:0], step_q};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FIX: begin
          div_by_zero <= dbz_q;
          overflow    <= ovf_q;
          if (dbz_q) begin
            quotient  <= neg_num_q ? MOST_NEG : MOST_POS;
            remainder <= num_q;
          end else if (ovf_q) begin
            quotient  <= MOST_NEG;
            remainder <= '0;
          end else begin
            quotient  <= neg_quo_q ? -dvd_q : dvd_q;
            remainder <= neg_num_q ? -rem_q : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hls2x8_div_seq.sv
// tb/tb_hls2x8_div_seq.sv - randomized self-checking bench for hls2x8_div_seq
module tb_hls2x8_div_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        ap_start = 1'b0;
  logic        ap_idle;
  logic        ap_ready;
  logic        ap_done;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  hls2x8_div_seq #(.DATA_WIDTH(16)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Truncating signed division reference with the two special cases
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic z, output logic o);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    z = 1'b0;
    o = 1'b0;
    if (sb == 0) begin
      z = 1'b1;
      q = (sa < 0) ? 16'h8000 : 16'h7fff;
      r = a;
    end else if (sa == -32768 && sb == -1) begin
      o = 1'b1;
      q = 16'h8000;
      r = 16'h0000;
    end else begin
      q = 16'(sa / sb);
      r = 16'(sa % sb);
    end
  endfunction

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hffff;
      2: return 16'h8000;
      3: return 16'h0001;
      4: return 16'h7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic ez, input logic eo);
    int cyc;
    @(negedge ap_clk);
    dividend = a;
    divisor  = b;
    ap_start = 1'b1;
    #1;
    check({tag, " ready_at_accept"}, ap_ready, 1);
    check({tag, " idle_at_accept"}, ap_idle, 1);
    @(negedge ap_clk);
    ap_start = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    cyc = 1;
    check({tag, " ready_after_accept"}, ap_ready, 0);
    check({tag, " idle_after_accept"}, ap_idle, 0);
    while (!ap_done && cyc < 40) begin
      @(negedge ap_clk);
      cyc++;
      ap_start = 1'($urandom_range(0, 1));
      dividend = 16'($urandom);
    end
    ap_start = 1'b0;
    check({tag, " latency"}, cyc, 18);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, ez);
    check({tag, " overflow"}, overflow, eo);
    @(negedge ap_clk);
    check({tag, " done_one_cycle"}, ap_done, 0);
    check({tag, " idle_return"}, ap_idle, 1);
    check({tag, " quotient_hold"}, quotient, eq);
  endtask

  logic [15:0] eq_q[$];
  logic [15:0] er_q[$];
  logic        ez_q[$];
  logic        eo_q[$];

  initial begin
    logic [15:0] a, b, mq, mr;
    logic        mz, mo;
    int          cyc, accepts, dones, last_acc, seen_done;

    #1;
    check("reset idle", ap_idle, 1);
    check("reset ready", ap_ready, 0);
    check("reset done", ap_done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset flags", {div_by_zero, overflow}, 0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;

    run_div("100/7",     16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 1'b0);
    run_div("-100/7",    16'hff9c,  16'd7,     16'hfff2,  16'hfffe,  1'b0, 1'b0);
    run_div("100/-7",    16'd100,   16'hfff9,  16'hfff2,  16'd2,     1'b0, 1'b0);
    run_div("-100/-7",   16'hff9c,  16'hfff9,  16'd14,    16'hfffe,  1'b0, 1'b0);
    run_div("5/0",       16'd5,     16'd0,     16'h7fff,  16'd5,     1'b1, 1'b0);
    run_div("-5/0",      16'hfffb,  16'd0,     16'h8000,  16'hfffb,  1'b1, 1'b0);
    run_div("min/-1",    16'h8000,  16'hffff,  16'h8000,  16'd0,     1'b0, 1'b1);
    run_div("min/1",     16'h8000,  16'd1,     16'h8000,  16'd0,     1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a = rand_op();
      b = rand_op();
      model(a, b, mq, mr, mz, mo);
      run_div($sformatf("rand%0d %0d/%0d", i, $signed(a), $signed(b)), a, b, mq, mr, mz, mo);
    end

    // ap_start held high: one accept every 19 cycles, garbage operands between accepts
    @(negedge ap_clk);
    dividend = rand_op();
    divisor  = rand_op();
    ap_start = 1'b1;
    accepts = 0;
    dones = 0;
    last_acc = -1;
    cyc = 0;
    while (dones < 20 && cyc < 1000) begin
      #1;
      if (ap_done) begin
        if (eq_q.size() == 0) begin
          check("b2b unexpected done", 1, 0);
        end else begin
          check("b2b quotient", quotient, eq_q.pop_front());
          check("b2b remainder", remainder, er_q.pop_front());
          check("b2b div_by_zero", div_by_zero, ez_q.pop_front());
          check("b2b overflow", overflow, eo_q.pop_front());
        end
        dones++;
      end
      if (ap_idle) begin
        if (accepts < 20) begin
          check("b2b ready", ap_ready, 1);
          if (last_acc >= 0) check("b2b interval", cyc - last_acc, 19);
          last_acc = cyc;
          model(dividend, divisor, mq, mr, mz, mo);
          eq_q.push_back(mq);
          er_q.push_back(mr);
          ez_q.push_back(mz);
          eo_q.push_back(mo);
          accepts++;
        end else begin
          ap_start = 1'b0;
        end
      end else begin
        dividend = rand_op();
        divisor  = rand_op();
      end
      @(negedge ap_clk);
      cyc++;
    end
    ap_start = 1'b0;
    check("b2b completions", dones, 20);

    // Known non-zero result registers before the abort
    run_div("pre-abort", 16'hff9c, 16'hfff9, 16'd14, 16'hfffe, 1'b0, 1'b0);
    @(negedge ap_clk);
    dividend = 16'd100;
    divisor  = 16'd7;
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    repeat (8) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    check("abort idle", ap_idle, 1);
    check("abort done", ap_done, 0);
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort flags", {div_by_zero, overflow}, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    seen_done = 0;
    repeat (25) begin
      @(negedge ap_clk);
      if (ap_done) seen_done++;
    end
    check("abort no done", seen_done, 0);
    run_div("post-abort 100/7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
